// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op codes and widths shared by the logic unit
package logic_unit_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_NAND = 3'd1;
   localparam logic [OP_W-1:0] OP_OR   = 3'd2;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise function with result flags
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ones,
   output logic             parity
);

   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_NAND: result = ~(a & b);
         OP_OR:   result = a | b;
         OP_NOR:  result = ~(a | b);
         OP_XOR:  result = a ^ b;
         OP_XNOR: result = ~(a ^ b);
         OP_NOT:  result = ~a;
         OP_PASS: result = a;
         default: result = '0;
      endcase
   end

   assign zero   = (result == '0);
   assign ones   = &result;
   assign parity = ^result;

endmodule

// File: rtl/logic_unit_nbit.sv
// rtl/logic_unit_nbit.sv - registered N-bit logic unit with handshake, chaining and counter
module logic_unit_nbit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic             use_acc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones,
   output logic             parity,
   output logic [CNT_W-1:0] op_count
);

   logic             accept;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] core_result;
   logic             core_zero;
   logic             core_ones;
   logic             core_parity;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // y loads only on accept, exactly like the accumulator, so y doubles as acc.
   assign a_sel = use_acc ? y : a;

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op     (op),
      .a      (a_sel),
      .b      (b),
      .result (core_result),
      .zero   (core_zero),
      .ones   (core_ones),
      .parity (core_parity)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
         zero      <= 1'b1;
         ones      <= 1'b0;
         parity    <= 1'b0;
         op_count  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         y         <= core_result;
         zero      <= core_zero;
         ones      <= core_ones;
         parity    <= core_parity;
         op_count  <= op_count + CNT_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_logic_unit_nbit.sv
// tb/tb_logic_unit_nbit.sv - scoreboard bench for logic_unit_nbit
module tb_logic_unit_nbit;

   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             use_acc;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;
   logic             ones;
   logic             parity;
   logic [CNT_W-1:0] op_count;

   typedef struct {
      int y;
      int zero;
      int ones;
      int parity;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // model state
   bit   m_ov  = 0;
   int   m_acc = 0;
   int   m_cnt = 0;

   logic_unit_nbit #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .use_acc   (use_acc),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .ones      (ones),
      .parity    (parity),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_op(input int o, input int x, input int z);
      int mask = (1 << WIDTH) - 1;
      case (o)
         0: return x & z;
         1: return mask - (x & z);
         2: return x | z;
         3: return mask - (x | z);
         4: return x ^ z;
         5: return mask - (x ^ z);
         6: return mask - x;
         default: return x;
      endcase
   endfunction

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
      check("rst out_valid", int'(out_valid), 0);
      check("rst y", int'(y), 0);
      check("rst zero", int'(zero), 1);
      check("rst ones", int'(ones), 0);
      check("rst parity", int'(parity), 0);
      check("rst op_count", int'(op_count), 0);
      exp_q.delete();
      m_ov = 0;
      m_acc = 0;
      m_cnt = 0;
      rst_n = 1'b1;
   endtask

   task automatic step(input bit iv, input int o, input bit ua, input int av, input int bv,
                       input bit ordy);
      bit   rdy;
      int   ry;
      exp_t e;
      in_valid  = iv;
      op        = 3'(o);
      use_acc   = ua;
      a         = WIDTH'(av);
      b         = WIDTH'(bv);
      out_ready = ordy;
      @(negedge clk);
      rdy = !m_ov || ordy;
      check("in_ready", int'(in_ready), int'(rdy));
      check("out_valid", int'(out_valid), int'(m_ov));
      check("op_count", int'(op_count), m_cnt);
      if (iv && rdy) begin
         ry = ref_op(o, ua ? m_acc : av, bv);
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
         e.y = ry;
         e.zero = (ry == 0);
         e.ones = (ry == (1 << WIDTH) - 1);
         e.parity = $countones(ry) % 2;
         e.cnt = m_cnt;
         exp_q.push_back(e);
         m_acc = ry;
         m_ov = 1;
      end else if (ordy) begin
         m_ov = 0;
      end
      @(posedge clk);
      #1;
   endtask

   // monitor: a result is consumed whenever out_valid && out_ready at the edge
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected result", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("y", int'(y), e.y);
            check("zero", int'(zero), e.zero);
            check("ones", int'(ones), e.ones);
            check("parity", int'(parity), e.parity);
            check("result op_count", int'(op_count), e.cnt);
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; op = '0; use_acc = 1'b0;
      a = '0; b = '0; out_ready = 1'b0;
      do_reset(2);

      step(1, 1, 0, 'hA, 'hC, 1);   // NAND -> 0x7
      step(1, 4, 1, 0,   'h3, 1);   // acc ^ 3 -> 0x4
      step(1, 6, 1, 0,   0,   1);   // ~acc -> 0xB
      step(1, 0, 0, 'hA, 'h5, 1);   // AND -> 0
      step(1, 2, 0, 'hA, 'h5, 1);   // OR -> 0xF
      step(0, 0, 0, 0,   0,   1);

      // backpressure: result held, new requests refused, then swap
      step(1, 4, 0, 'h9, 'h6, 0);
      for (int i = 0; i < 4; i++) step(1, 3, 0, 'h1, 'h2, 0);
      check("stall y", int'(y), 'hF);
      step(1, 3, 0, 'h1, 'h2, 1);
      step(0, 0, 0, 0, 0, 1);

      // counter wrap and reset with a result pending
      do_reset(1);
      for (int i = 0; i < 5; i++) step(1, 7, 0, i, 0, 1);
      check("wrap op_count", int'(op_count), 1);
      do_reset(1);
      step(1, 7, 1, 'h5, 0, 1);     // chained PASS after reset sees acc=0
      step(1, 5, 1, 0, 'h3, 1);     // ~(0 ^ 3) -> 0xC

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
      check("queue drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
